pushbutton_irq_servicer: RTL and testbench
==========================================

Name: pushbutton_irq_servicer

Overview:
- Avalon-MM master that owns the 2-bit pushbutton PIO's register interface.
- After reset, programs the PIO IRQ mask. On PIO irq, reads and clears the edge-capture register.
- Arbitrates the captured buttons into a single valid/ready event stream toward the SHA1 control logic, lowest-numbered button first.
- Applies a debounce hold-off, then flushes bounce captures of the buttons just served.

Parameters:
- MASK_INIT, 2'b11, IRQ mask written to the PIO after reset.
- HOLDOFF_CYCLES, 50000, debounce hold-off length in clk cycles; 0 = no hold-off.
- CNT_W, 16, hold-off counter width; must satisfy HOLDOFF_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous and active-low.
- irq  in  1  PIO interrupt, level.
- pio_address  out  2  PIO register select: 2 = irq_mask, 3 = edge_capture.
- pio_chipselect  out  1  PIO chipselect.
- pio_write_n  out  1  PIO write strobe, active-low.
- pio_writedata  out  32  PIO write data; bits [31:2] always 0.
- pio_readdata  in  32  PIO read data, registered in the PIO (valid the cycle after the address is presented).
- mask_update  in  1  one-cycle pulse requesting a new IRQ mask.
- mask_value  in  2  new mask, sampled while mask_update = 1.
- evt_valid  out  1  button event available.
- evt_id  out  1  button index of the current event.
- evt_ready  in  1  consumer accepts the event.
- busy  out  1  1 in every state except IDLE.

Behaviour:
- Reset (async, reset_n = 0) values:
  - outputs: pio_address = 0, pio_chipselect = 0, pio_write_n = 1, pio_writedata = 0, evt_valid = 0, evt_id = 0, busy = 1.
  - internal: state = MASK_WR, mask_reg = MASK_INIT, upd_pend = 0, pend = 0, served = 0, counter = 0.
- Bus outputs are registered and decoded from state. Idle bus = chipselect 0, write_n 1, address 0, writedata 0.
- MASK_WR, 1 cycle: address 2, chipselect 1, write_n 0, writedata = mask_reg. Clears upd_pend. Next state IDLE.
- IDLE:
  - If upd_pend, go to MASK_WR.
  - Else if irq, go to RD_ADDR.
  - A mask update has priority over irq.
- RD_ADDR, 1 cycle: address 3, chipselect 1, write_n 1. Next state RD_CAP.
- RD_CAP, 1 cycle: bus idle. Latch pend <= pio_readdata[1:0] & mask_reg.
  - If the latched value is 0 (spurious irq), go to IDLE with no write.
  - Otherwise go to CLEAR.
- CLEAR, 1 cycle: address 3, chipselect 1, write_n 0, writedata = pend (write-1-to-clear of the captured bits only). Set served = pend. Next state DISPATCH.
- DISPATCH:
  - evt_valid = 1; evt_id = index of the lowest set bit of pend.
  - evt_valid and evt_id hold stable until evt_ready.
  - On evt_valid && evt_ready: clear that bit of pend.
  - If bits remain, evt_valid stays 1 and evt_id updates the next cycle.
  - When pend becomes 0: evt_valid drops the next cycle. Go to HOLDOFF with counter = HOLDOFF_CYCLES - 1, or straight to FLUSH if HOLDOFF_CYCLES = 0.
- HOLDOFF: bus idle, irq ignored, counter decrements. At counter = 0, go to FLUSH.
- FLUSH, 1 cycle: address 3, chipselect 1, write_n 0, writedata = served. This discards bounce edges of the served buttons only; other buttons' captures survive. Then served = 0 and the next state is IDLE.
- mask_update:
  - In any state, a pulse sets upd_pend = 1 and mask_reg = mask_value.
  - The PIO write happens at the next IDLE.
  - The latest value wins if several pulses arrive.
- Latency: irq high in IDLE at cycle 0 → RD_ADDR at 1, RD_CAP at 2, CLEAR at 3, evt_valid = 1 at cycle 4.
- Total service time (both buttons, evt_ready held 1): 4 + 2 + HOLDOFF_CYCLES + 1 cycles back to IDLE.
- Reset mid-operation: all state is abandoned immediately. Any pending event is lost and no partial bus transfer is extended. After release, MASK_WR reprograms the mask.

Test Plan:
- Reset release, MASK_INIT = 2'b11 → cycle 1 after release: address 2, chipselect 1, write_n 0, writedata 0x3. Then IDLE with busy = 0.
- Button 1 press, HOLDOFF_CYCLES = 4, evt_ready = 1 → write 0x2 to address 3 at cycle 3; evt_valid with evt_id = 1 at cycle 4 for one cycle; 4 idle cycles; FLUSH write 0x2; IDLE.
- Edge capture = 0x3, evt_ready low for 5 cycles → evt_id = 0 held 5 cycles; on ready, evt_id = 1 the next cycle; then evt_valid = 0 and FLUSH writedata = 0x3.
- Button 0 bounces during HOLDOFF while button 1 presses → FLUSH writes 0x1 only; irq stays high; a second service round delivers evt_id = 1.
- mask_update pulse with mask_value = 2'b01 during DISPATCH → no bus write until IDLE. Then MASK_WR writes 0x1 to address 2 before any pending irq is serviced.
- Spurious irq with readdata = 0 → no CLEAR write, no event; back to IDLE at cycle 3. Reset asserted in HOLDOFF → outputs return to reset values asynchronously, then MASK_WR follows release.

Source files
------------

// File: rtl/pushbutton_irq_servicer.sv
// Avalon-MM master servicing a 2-bit pushbutton PIO: programs its IRQ mask, reads and
// clears edge captures, and hands captured buttons out as a valid/ready event stream.
module pushbutton_irq_servicer #(
    parameter logic [1:0]  MASK_INIT      = 2'b11,
    parameter int unsigned HOLDOFF_CYCLES = 50000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        irq,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    input  logic        mask_update,
    input  logic [1:0]  mask_value,
    output logic        evt_valid,
    output logic        evt_id,
    input  logic        evt_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_MASK_WR,
        S_IDLE,
        S_RD_ADDR,
        S_RD_CAP,
        S_CLEAR,
        S_DISPATCH,
        S_HOLDOFF,
        S_FLUSH
    } state_t;

    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

    state_t             state_q, state_d;
    logic [1:0]         mask_q, mask_d;
    logic               upd_pend_q, upd_pend_d;
    logic [1:0]         pend_q, pend_d;
    logic [1:0]         served_q, served_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         addr_q, addr_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [1:0]         wd_q, wd_d;
    logic               evt_valid_q, evt_valid_d;
    logic               evt_id_q, evt_id_d;
    logic               busy_q, busy_d;

    logic [1:0]         cap_masked;
    logic [1:0]         accept_bit;
    logic               mask_wr_done;
    logic               unused_rd;

    assign cap_masked = pio_readdata[1:0] & mask_q;
    assign accept_bit = evt_id_q ? 2'b10 : 2'b01;
    assign unused_rd  = ^pio_readdata[31:2];

    // Bus outputs lag the state they are decoded from by one register, so MASK_WR is
    // left only once its write is actually on the bus (this also covers reset exit).
    assign mask_wr_done = cs_q && !wn_q && (addr_q == ADDR_MASK);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_MASK_WR;
            mask_q      <= MASK_INIT;
            upd_pend_q  <= 1'b0;
            pend_q      <= 2'b00;
            served_q    <= 2'b00;
            cnt_q       <= '0;
            addr_q      <= 2'd0;
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            wd_q        <= 2'b00;
            evt_valid_q <= 1'b0;
            evt_id_q    <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            upd_pend_q  <= upd_pend_d;
            pend_q      <= pend_d;
            served_q    <= served_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            wn_q        <= wn_d;
            wd_q        <= wd_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        upd_pend_d = upd_pend_q;
        pend_d     = pend_q;
        served_d   = served_q;
        cnt_d      = cnt_q;

        if (state_q == S_MASK_WR && mask_wr_done) begin
            upd_pend_d = 1'b0;
        end
        // A new request always wins, even one arriving during the mask write itself.
        if (mask_update) begin
            mask_d     = mask_value;
            upd_pend_d = 1'b1;
        end

        case (state_q)
            S_MASK_WR: begin
                if (mask_wr_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (upd_pend_q) begin
                    state_d = S_MASK_WR;
                end else if (irq) begin
                    state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                pend_d  = cap_masked;
                state_d = (cap_masked == 2'b00) ? S_IDLE : S_CLEAR;
            end
            S_CLEAR: begin
                served_d = pend_q;
                state_d  = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (evt_valid_q && evt_ready) begin
                    pend_d = pend_q & ~accept_bit;
                    if ((pend_q & ~accept_bit) == 2'b00) begin
                        if (HOLDOFF_CYCLES == 0) begin
                            state_d = S_FLUSH;
                        end else begin
                            state_d = S_HOLDOFF;
                            cnt_d   = HOLD_LOAD;
                        end
                    end
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FLUSH: begin
                served_d = 2'b00;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_MASK_WR;
            end
        endcase
    end

    // Output decode from the upcoming state, registered
    always_comb begin
        addr_d      = 2'd0;
        cs_d        = 1'b0;
        wn_d        = 1'b1;
        wd_d        = 2'b00;
        evt_valid_d = 1'b0;
        evt_id_d    = 1'b0;
        busy_d      = (state_d != S_IDLE);

        case (state_d)
            S_MASK_WR: begin
                addr_d = ADDR_MASK;
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                wd_d   = mask_d;
            end
            S_RD_ADDR: begin
                addr_d = ADDR_EDGE;
                cs_d   = 1'b1;
            end
            S_CLEAR: begin
                addr_d = ADDR_EDGE;
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                wd_d   = pend_d;
            end
            S_DISPATCH: begin
                evt_valid_d = 1'b1;
                evt_id_d    = ~pend_d[0];
            end
            S_FLUSH: begin
                addr_d = ADDR_EDGE;
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                wd_d   = served_d;
            end
            default: begin
                addr_d = 2'd0;
            end
        endcase
    end

    assign pio_address    = addr_q;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = wn_q;
    assign pio_writedata  = {30'b0, wd_q};
    assign evt_valid      = evt_valid_q;
    assign evt_id         = evt_id_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_pushbutton_irq_servicer.sv
// Bench for pushbutton_irq_servicer: a behavioural PIO slave, directed steps from the
// test plan, then randomized mask/press rounds checked against an arithmetic model.
module tb_pushbutton_irq_servicer;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        irq;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = 32'h0;
    logic        mask_update;
    logic [1:0]  mask_value;
    logic        evt_valid;
    logic        evt_id;
    logic        evt_ready;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // PIO slave model
    logic [1:0] cap_m = 2'b00;
    logic [1:0] mask_m = 2'b00;
    logic [1:0] press_bits = 2'b00;
    logic       spur = 1'b0;

    always #5 clk = ~clk;

    pushbutton_irq_servicer #(
        .MASK_INIT      (2'b11),
        .HOLDOFF_CYCLES (HOLD),
        .CNT_W          (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .irq            (irq),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .mask_update    (mask_update),
        .mask_value     (mask_value),
        .evt_valid      (evt_valid),
        .evt_id         (evt_id),
        .evt_ready      (evt_ready),
        .busy           (busy)
    );

    always @(posedge clk) begin
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
            mask_m <= pio_writedata[1:0];
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
            cap_m <= (cap_m & ~pio_writedata[1:0]) | press_bits;
        else
            cap_m <= cap_m | press_bits;
        if (pio_address == 2'd3)      pio_readdata <= {30'b0, cap_m};
        else if (pio_address == 2'd2) pio_readdata <= {30'b0, mask_m};
        else                          pio_readdata <= 32'h0;
    end

    assign irq = (|(cap_m & mask_m)) | spur;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input int a, input int wn, input int wd);
        chk({tag, "_cs"}, 32'(pio_chipselect), 1);
        chk({tag, "_addr"}, 32'(pio_address), 32'(a));
        chk({tag, "_wn"}, 32'(pio_write_n), 32'(wn));
        if (wn == 0) chk({tag, "_wd"}, pio_writedata, 32'(wd));
    endtask

    task automatic press(input logic [1:0] b);
        press_bits = b;
        tick();
        press_bits = 2'b00;
    endtask

    // Entered in the IDLE cycle that sees irq, with evt_ready held 1.
    task automatic round(input logic [1:0] cap, input logic [1:0] bounce);
        tick(); chk_bus("rd_addr", 3, 1, 0);
        tick(); chk("rd_cap_cs", 32'(pio_chipselect), 0);
        tick(); chk_bus("clear", 3, 0, 32'(cap));
        for (int b = 0; b < 2; b++) begin
            if (cap[b]) begin
                tick();
                chk("disp_valid", 32'(evt_valid), 1);
                chk("disp_id", 32'(evt_id), 32'(b));
            end
        end
        for (int h = 0; h < HOLD; h++) begin
            tick();
            if (h == 0) press_bits = bounce;
            if (h == 1) press_bits = 2'b00;
            chk("hold_valid", 32'(evt_valid), 0);
            chk("hold_cs", 32'(pio_chipselect), 0);
            chk("hold_busy", 32'(busy), 1);
        end
        tick(); chk_bus("flush", 3, 0, 32'(cap));
        tick(); chk("idle_busy", 32'(busy), 0);
    endtask

    logic [1:0] left_m, rm, rp, serve;
    int         exp_q[$];
    int         got_q[$];
    int         nwr2, nwr3;
    logic       prev_stall, prev_id;

    initial begin
        reset_n = 1'b1;
        mask_update = 1'b0;
        mask_value = 2'b00;
        evt_ready = 1'b1;
        #2 reset_n = 1'b0;
        tick();
        chk("rst_addr", 32'(pio_address), 0);
        chk("rst_cs", 32'(pio_chipselect), 0);
        chk("rst_wn", 32'(pio_write_n), 1);
        chk("rst_wd", pio_writedata, 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_id", 32'(evt_id), 0);
        chk("rst_busy", 32'(busy), 1);
        tick();
        reset_n = 1'b1;
        tick(); chk_bus("init_mask", 2, 0, 3); chk("init_busy", 32'(busy), 1);
        tick(); chk("init_idle_busy", 32'(busy), 0); chk("init_idle_cs", 32'(pio_chipselect), 0);

        // Single button 1
        press(2'b10);
        round(2'b10, 2'b00);

        // Both buttons with a stalled consumer
        evt_ready = 1'b0;
        press(2'b11);
        tick(); tick();
        tick(); chk_bus("both_clear", 3, 0, 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(evt_valid), 1);
            chk("stall_id", 32'(evt_id), 0);
        end
        evt_ready = 1'b1;
        tick(); chk("both_valid1", 32'(evt_valid), 1); chk("both_id1", 32'(evt_id), 1);
        for (int h = 0; h < HOLD; h++) begin
            tick(); chk("both_hold_valid", 32'(evt_valid), 0);
        end
        tick(); chk_bus("both_flush", 3, 0, 3);
        tick(); chk("both_idle", 32'(busy), 0);

        // Button 0 bounces during hold-off while button 1 is pressed
        press(2'b01);
        round(2'b01, 2'b11);
        round(2'b10, 2'b00);

        // Mask update during DISPATCH waits for IDLE and beats a pending irq
        evt_ready = 1'b0;
        press(2'b01);
        tick(); tick();
        tick(); chk_bus("mu_clear", 3, 0, 1);
        tick(); chk("mu_valid", 32'(evt_valid), 1); chk("mu_id", 32'(evt_id), 0);
        mask_update = 1'b1; mask_value = 2'b01; press_bits = 2'b10;
        tick();
        mask_update = 1'b0; press_bits = 2'b00;
        chk("mu_no_write", 32'(pio_chipselect), 0);
        chk("mu_valid_hold", 32'(evt_valid), 1);
        evt_ready = 1'b1;
        for (int h = 0; h < HOLD; h++) begin
            tick(); chk("mu_hold_cs", 32'(pio_chipselect), 0);
        end
        tick(); chk_bus("mu_flush", 3, 0, 1);
        tick(); chk("mu_idle_cs", 32'(pio_chipselect), 0);
        tick(); chk_bus("mu_mask_wr", 2, 0, 1);
        tick(); chk("mu_after_cs", 32'(pio_chipselect), 0); chk("mu_after_busy", 32'(busy), 0);
        tick(); chk("mu_masked_cs", 32'(pio_chipselect), 0); chk("mu_masked_busy", 32'(busy), 0);
        mask_update = 1'b1; mask_value = 2'b11;
        tick();
        mask_update = 1'b0;
        chk("mu2_cs", 32'(pio_chipselect), 0);
        tick(); chk_bus("mu2_mask_wr", 2, 0, 3);
        tick();
        round(2'b10, 2'b00);

        // Spurious irq
        spur = 1'b1;
        tick(); chk_bus("sp_rd_addr", 3, 1, 0);
        spur = 1'b0;
        tick();
        tick(); chk("sp_idle_busy", 32'(busy), 0); chk("sp_idle_cs", 32'(pio_chipselect), 0);
        tick(); chk("sp_no_write", 32'(pio_chipselect), 0); chk("sp_no_evt", 32'(evt_valid), 0);

        // Reset during hold-off
        press(2'b01);
        tick(); tick(); tick();
        tick(); chk("rh_valid", 32'(evt_valid), 1);
        tick(); chk("rh_in_hold", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("rh_cs", 32'(pio_chipselect), 0);
        chk("rh_wn", 32'(pio_write_n), 1);
        chk("rh_addr", 32'(pio_address), 0);
        chk("rh_valid0", 32'(evt_valid), 0);
        chk("rh_busy", 32'(busy), 1);
        tick(); tick();
        reset_n = 1'b1;
        tick(); chk_bus("rh_mask_wr", 2, 0, 3);
        tick(); chk("rh_idle", 32'(busy), 0);

        // Randomized rounds: new mask and presses together, reference computed arithmetically
        left_m = 2'b00;
        for (int it = 0; it < 10; it++) begin
            rm = 2'($urandom_range(1, 3));
            rp = 2'($urandom_range(1, 3));
            serve  = (rp | left_m) & rm;
            left_m = (rp | left_m) & ~rm;
            exp_q.delete();
            got_q.delete();
            for (int b = 0; b < 2; b++) if (serve[b]) exp_q.push_back(b);
            mask_update = 1'b1; mask_value = rm; press_bits = rp;
            tick();
            mask_update = 1'b0; press_bits = 2'b00;
            nwr2 = 0; nwr3 = 0; prev_stall = 1'b0; prev_id = 1'b0;
            for (int c = 0; c < 60; c++) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                if (prev_stall) begin
                    chk("rnd_stall_valid", 32'(evt_valid), 1);
                    chk("rnd_stall_id", 32'(evt_id), 32'(prev_id));
                end
                if (pio_chipselect && !pio_write_n) begin
                    if (pio_address == 2'd2) begin
                        nwr2++;
                        chk("rnd_mask_wd", pio_writedata, 32'(rm));
                    end else begin
                        nwr3++;
                        chk("rnd_w1c_wd", pio_writedata, 32'(serve));
                    end
                end
                if (evt_valid && evt_ready) got_q.push_back(int'(evt_id));
                prev_stall = evt_valid && !evt_ready;
                prev_id = evt_id;
                tick();
            end
            evt_ready = 1'b1;
            chk("rnd_mask_writes", 32'(nwr2), 1);
            chk("rnd_edge_writes", 32'(nwr3), (serve != 2'b00) ? 2 : 0);
            chk("rnd_evt_count", 32'(got_q.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
                chk("rnd_evt_id", 32'(got_q[k]), 32'(exp_q[k]));
            chk("rnd_end_busy", 32'(busy), 0);
            $display("round %0d: mask=%0d press=%0d serve=%0d events=%0d", it, rm, rp, serve, got_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
